// File: rtl/sp_pkg.sv
// Shared sizes, reservation-slot type and slot-index helper for the singlePrec issue controller.
package sp_pkg;

   localparam int NREG        = 128;
   localparam int RADDR_W     = 7;
   localparam int LAT6        = 6;
   localparam int LAT7        = 7;
   localparam int TABLE_DEPTH = 8;

   typedef logic [$clog2(TABLE_DEPTH)-1:0] slot_idx_t;

   typedef struct packed {
      logic               valid;
      logic [RADDR_W-1:0] rt;
   } rsv_slot_t;

   // Slot 0 is the writeback register, so a latency-L result enters at slot L-1.
   function automatic slot_idx_t ins_slot(input logic lat7);
      return lat7 ? slot_idx_t'(LAT7 - 1) : slot_idx_t'(LAT6 - 1);
   endfunction

endpackage

// File: rtl/sp_scoreboard.sv
// Reservation shift register (writeback scheduling) and per-register pending vector.
module sp_scoreboard
   import sp_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_flush,
   input  logic               i_set_en,
   input  logic               i_lat,
   input  logic [RADDR_W-1:0] i_set_rt,
   output logic               o_port_busy,
   output logic [NREG-1:0]    o_pending,
   output logic               o_wb_valid,
   output logic [RADDR_W-1:0] o_wb_rt
);

   rsv_slot_t [TABLE_DEPTH-1:0] r_tbl;
   logic [NREG-1:0]             r_pending;
   slot_idx_t                   w_ins;

   assign w_ins = ins_slot(i_lat);

   // The entry now at index L shifts into L-1 this edge, the slot a new issue would claim.
   assign o_port_busy = i_lat ? r_tbl[LAT7].valid : r_tbl[LAT6].valid;

   assign o_pending  = r_pending;
   assign o_wb_valid = r_tbl[0].valid;
   assign o_wb_rt    = r_tbl[0].rt;

   // NOTE: the table and pending vector are small flop arrays, not RAM, so they take the async reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tbl     <= '0;
         r_pending <= '0;
      end else if (i_flush) begin
         r_tbl     <= '0;
         r_pending <= '0;
      end else begin
         r_tbl <= {rsv_slot_t'('0), r_tbl[TABLE_DEPTH-1:1]};
         if (i_set_en)
            r_tbl[w_ins] <= {1'b1, i_set_rt};
         if (r_tbl[0].valid)
            r_pending[r_tbl[0].rt] <= 1'b0;
         // NOTE: the later non-blocking assignment wins, so a same-cycle set overrides the writeback clear.
         if (i_set_en)
            r_pending[i_set_rt] <= 1'b1;
      end
   end

endmodule

// File: rtl/sp_issue_ctrl.sv
// Issue controller for the singlePrec pipe: RAW/WAW/write-port hazards, writeback scheduling, stall counter.
// Define SP_ISSUE_FWD_EN to exempt from RAW a source that is being written back this cycle.
module sp_issue_ctrl
   import sp_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_lat,
   input  logic [RADDR_W-1:0] in_ra_addr,
   input  logic [RADDR_W-1:0] in_rb_addr,
   input  logic [RADDR_W-1:0] in_rc_addr,
   input  logic [2:0]         in_use,
   input  logic [RADDR_W-1:0] in_rt_addr,
   input  logic               in_wr,
   input  logic               flush,
   output logic               iss_valid,
   output logic [RADDR_W-1:0] iss_rt,
   output logic               iss_lat,
   output logic               wb_valid,
   output logic [RADDR_W-1:0] wb_rt,
   output logic               busy,
   output logic [15:0]        stall_cnt
);

   logic               r_rdy_en;
   logic [15:0]        r_stall_cnt;
   logic [NREG-1:0]    w_pending;
   logic               w_port_busy;
   logic [2:0]         w_src_hit;
   logic [RADDR_W-1:0] w_src [3];
   logic               w_raw;
   logic               w_waw;
   logic               w_port;

   assign w_src = '{in_ra_addr, in_rb_addr, in_rc_addr};

   // NOTE: w_src_hit gets its default first so every path assigns it and no latch is inferred.
   always_comb begin
      w_src_hit = '0;
      for (int i = 0; i < 3; i++) begin
         w_src_hit[i] = in_use[i] & w_pending[w_src[i]];
`ifdef SP_ISSUE_FWD_EN
         if (wb_valid && (wb_rt == w_src[i]))
            w_src_hit[i] = 1'b0;
`endif
      end
   end

   assign w_raw  = |w_src_hit;
   assign w_waw  = in_wr & w_pending[in_rt_addr];
   assign w_port = in_wr & w_port_busy;

   assign in_ready  = r_rdy_en & ~flush & ~w_raw & ~w_waw & ~w_port;
   assign iss_valid = in_valid & in_ready;
   assign iss_rt    = in_rt_addr;
   assign iss_lat   = in_lat;
   assign busy      = |w_pending;
   assign stall_cnt = r_stall_cnt;

   sp_scoreboard u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (flush),
      .i_set_en    (iss_valid & in_wr),
      .i_lat       (in_lat),
      .i_set_rt    (in_rt_addr),
      .o_port_busy (w_port_busy),
      .o_pending   (w_pending),
      .o_wb_valid  (wb_valid),
      .o_wb_rt     (wb_rt)
   );

   // Holds in_ready low until the first rising edge after reset is released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_rdy_en <= 1'b0;
      else
         r_rdy_en <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= '0;
      else if (in_valid && !in_ready && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_sp_issue_ctrl.sv
// Self-checking bench for sp_issue_ctrl: vector table, directed hazard/flush/reset sequences, random traffic vs model.
module tb_sp_issue_ctrl;
   import sp_pkg::*;

`ifdef SP_ISSUE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_lat = 1'b0;
   logic [6:0] in_ra_addr = '0;
   logic [6:0] in_rb_addr = '0;
   logic [6:0] in_rc_addr = '0;
   logic [2:0] in_use = '0;
   logic [6:0] in_rt_addr = '0;
   logic       in_wr = 1'b0;
   logic       flush = 1'b0;
   logic       in_ready;
   logic       iss_valid;
   logic [6:0] iss_rt;
   logic       iss_lat;
   logic       wb_valid;
   logic [6:0] wb_rt;
   logic       busy;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   sp_issue_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_lat     (in_lat),
      .in_ra_addr (in_ra_addr),
      .in_rb_addr (in_rb_addr),
      .in_rc_addr (in_rc_addr),
      .in_use     (in_use),
      .in_rt_addr (in_rt_addr),
      .in_wr      (in_wr),
      .flush      (flush),
      .iss_valid  (iss_valid),
      .iss_rt     (iss_rt),
      .iss_lat    (iss_lat),
      .wb_valid   (wb_valid),
      .wb_rt      (wb_rt),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: in-flight writes as {rt, absolute writeback cycle}.
   typedef struct {int rt; int wb;} flight_t;
   flight_t m_q[$];
   int      cyc = 0;
   bit      m_ready_en = 1'b0;
   int      m_stall = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, got, exp, cyc, $time);
      end
   endtask

   function automatic bit m_pending(input int r);
      foreach (m_q[i])
         if (m_q[i].rt == r && m_q[i].wb >= cyc) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_wb_at(input int c, output int rt);
      rt = 0;
      foreach (m_q[i])
         if (m_q[i].wb == c) begin
            rt = m_q[i].rt;
            return 1'b1;
         end
      return 1'b0;
   endfunction

   function automatic bit m_busy();
      foreach (m_q[i])
         if (m_q[i].wb >= cyc) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ready();
      int wrt;
      bit wbv;
      int src[3];
      if (!m_ready_en || flush) return 1'b0;
      wbv = m_wb_at(cyc, wrt);
      src = '{int'(in_ra_addr), int'(in_rb_addr), int'(in_rc_addr)};
      for (int i = 0; i < 3; i++)
         if (in_use[i] && m_pending(src[i]) && !(FWD && wbv && wrt == src[i])) return 1'b0;
      if (in_wr) begin
         if (m_pending(int'(in_rt_addr))) return 1'b0;
         if (m_wb_at(cyc + (in_lat ? LAT7 : LAT6), wrt)) return 1'b0;
      end
      return 1'b1;
   endfunction

   // One clock: drive, check every output at negedge against the model, advance the model at posedge.
   task automatic step(input logic v, input logic lt, input logic wr, input logic [6:0] rt,
                       input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                       input logic [2:0] use_f, input logic fl,
                       output logic g_rdy, output logic g_wbv, output logic [6:0] g_wbrt,
                       output logic g_busy);
      bit e_rdy;
      bit e_wbv;
      int e_wbrt;
      in_valid = v; in_lat = lt; in_wr = wr; in_rt_addr = rt;
      in_ra_addr = ra; in_rb_addr = rb; in_rc_addr = rc; in_use = use_f; flush = fl;
      @(negedge clk);
      e_rdy = m_ready();
      e_wbv = m_wb_at(cyc, e_wbrt);
      check("in_ready", 32'(in_ready), 32'(e_rdy));
      check("iss_valid", 32'(iss_valid), 32'(v & e_rdy));
      check("iss_rt", 32'(iss_rt), 32'(rt));
      check("iss_lat", 32'(iss_lat), 32'(lt));
      check("wb_valid", 32'(wb_valid), 32'(e_wbv));
      check("wb_rt", 32'(wb_rt), e_wbv ? 32'(e_wbrt) : 32'd0);
      check("busy", 32'(busy), 32'(m_busy()));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      g_rdy = in_ready; g_wbv = wb_valid; g_wbrt = wb_rt; g_busy = busy;
      @(posedge clk);
      if (fl)
         m_q.delete();
      else if (v && e_rdy && wr)
         m_q.push_back('{rt: int'(rt), wb: cyc + (lt ? LAT7 : LAT6)});
      if (v && !e_rdy && m_stall < 65535) m_stall++;
      for (int i = m_q.size() - 1; i >= 0; i--)
         if (m_q[i].wb <= cyc) m_q.delete(i);
      cyc++;
      m_ready_en = 1'b1;
      #1;
   endtask

   typedef struct {
      logic       v, lat, wr;
      logic [6:0] rt;
      logic       e_rdy, e_wbv;
      logic [6:0] e_wbrt;
      logic       e_busy;
   } vec_t;
   vec_t tbl[18];

   logic       g_rdy, g_wbv, g_busy;
   logic [6:0] g_wbrt;
   int         acc;
   int         wbcnt;

   initial begin
      // lat-6 rt=5 writes back exactly 6 cycles later; then lat-7 rt=1 / lat-6 rt=2 port conflict.
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 7'd5, 1'b1, 1'b0, 7'd0, 1'b0};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'd5, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 7'd1, 1'b1, 1'b0, 7'd0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 7'd2, 1'b0, 1'b0, 7'd0, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 7'd2, 1'b1, 1'b0, 7'd0, 1'b1};
      for (int i = 11; i <= 14; i++)
         tbl[i] = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'd1, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'd2, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0};

      // Reset state, then in_ready stays low until the first edge after release.
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_rt", 32'(wb_rt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rdy_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
      m_ready_en = 1'b1;
      check("rdy_after_edge", 32'(in_ready), 32'd1);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].v, tbl[i].lat, tbl[i].wr, tbl[i].rt, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0,
              g_rdy, g_wbv, g_wbrt, g_busy);
         check("tbl_ready", 32'(g_rdy), 32'(tbl[i].e_rdy));
         check("tbl_wb_valid", 32'(g_wbv), 32'(tbl[i].e_wbv));
         check("tbl_wb_rt", 32'(g_wbrt), 32'(tbl[i].e_wbrt));
         check("tbl_busy", 32'(g_busy), 32'(tbl[i].e_busy));
      end

      // RAW on rt=3 after a lat-7 write: accepted in the wb cycle with bypass, one later without.
      step(1'b1, 1'b1, 1'b1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      acc = 0;
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b0, 1'b0, 7'd0, 7'd3, 7'd0, 7'd0, 3'b001, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
         if (g_rdy) begin
            acc = k;
            break;
         end
      end
      check("raw_accept_offset", 32'(acc), FWD ? 32'd7 : 32'd8);
      repeat (10) step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);

      // WAW rt=4 back-to-back: the second waits until after the first writeback.
      step(1'b1, 1'b0, 1'b1, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      acc = 0;
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b0, 1'b1, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
         if (g_rdy) begin
            acc = k;
            break;
         end
      end
      check("waw_accept_offset", 32'(acc), 32'd7);
      step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      check("waw_pending_reset", 32'(g_busy), 32'd1);
      repeat (8) step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);

      // Flush with three results in flight.
      step(1'b1, 1'b0, 1'b1, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      step(1'b1, 1'b0, 1'b1, 7'd11, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      step(1'b1, 1'b0, 1'b1, 7'd12, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, g_rdy, g_wbv, g_wbrt, g_busy);
      check("flush_ready", 32'(g_rdy), 32'd0);
      wbcnt = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
         if (g_wbv) wbcnt++;
      end
      check("flush_wb_count", 32'(wbcnt), 32'd0);
      check("flush_busy", 32'(g_busy), 32'd0);

      // Reset mid-operation with three results in flight.
      step(1'b1, 1'b1, 1'b1, 7'd20, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      step(1'b1, 1'b1, 1'b1, 7'd21, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      step(1'b1, 1'b1, 1'b1, 7'd22, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
      in_valid = 1'b0; in_wr = 1'b0;
      reset = 1'b0;
      #1;
      m_q.delete();
      m_stall = 0;
      m_ready_en = 1'b0;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
      check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_rdy_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
      m_ready_en = 1'b1;
      wbcnt = 0;
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, g_rdy, g_wbv, g_wbrt, g_busy);
         if (g_wbv) wbcnt++;
      end
      check("mid_rst_wb_count", 32'(wbcnt), 32'd0);

      // Random traffic on a small register window to provoke hazards.
      for (int k = 0; k < 600; k++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
              7'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 24) == 0),
              g_rdy, g_wbv, g_wbrt, g_busy);
      end

      // Stall-counter saturation: 70000 stalled cycles held off by flush.
      in_valid = 1'b1; in_wr = 1'b0; in_use = 3'b000; flush = 1'b1;
      for (int k = 0; k < 70000; k++) @(posedge clk);
      #1;
      cyc += 70000;
      m_q.delete();
      m_stall = 65535;
      check("stall_saturated", 32'(stall_cnt), 32'hFFFF);
      step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, g_rdy, g_wbv, g_wbrt, g_busy);
      step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, g_rdy, g_wbv, g_wbrt, g_busy);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
